demux_4ch_tdm: RTL and testbench

Four-channel time-division demultiplexer: the receive-side counterpart of the 4:1 channel multiplexer. It takes a serial stream of W-bit beats, one beat per slot, four slots per frame with slot 0 flagged by `sof`. It routes each beat to its channel staging register and presents all four channels together as a coherent, double-buffered frame once slot 3 arrives. It sits at the far end of the mux link, restoring the four parallel channels and flagging framing errors.

---
 rtl/demux_4ch_tdm.sv | 79 +++++++
 tb/tb_demux_4ch_tdm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_4ch_tdm.sv
// Four-channel TDM demultiplexer: collects slot 0..3 beats into staging and
// publishes all four channels together as one double-buffered frame.
module demux_4ch_tdm #(
  parameter int W = 1
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         din_valid,
  input  logic         sof,
  input  logic [W-1:0] din,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [1:0]   slot,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [3:0][W-1:0]    stg;
  logic [3:0][W-1:0]    chq;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state       <= IDLE;
      slot        <= 2'd0;
      stg         <= '0;
      chq         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          IDLE: begin
            if (sof) begin
              stg[0] <= din;
              slot   <= 2'd1;
              state  <= RUN;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RUN: begin
            if (sof) begin
              // early sof: drop the partial frame and restart on this beat
              frame_err <= 1'b1;
              stg[0]    <= din;
              slot      <= 2'd1;
            end else if (slot == 2'd3) begin
              // slot 3 bypasses staging so the frame publishes on this edge
              stg[3]      <= din;
              chq         <= {din, stg[2], stg[1], stg[0]};
              frame_valid <= 1'b1;
              slot        <= 2'd0;
              state       <= IDLE;
            end else begin
              stg[slot] <= din;
              slot      <= slot + 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == RUN);
  assign ch0  = chq[0];
  assign ch1  = chq[1];
  assign ch2  = chq[2];
  assign ch3  = chq[3];

endmodule

// File: tb/tb_demux_4ch_tdm.sv
// Bench for demux_4ch_tdm: directed vector table, hand sequences, randomized
// traffic against a queue-based frame model, and exhaustive W=1 patterns.
module tb_demux_4ch_tdm;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  always #5 CK = ~CK;

  logic       v8 = 0, s8 = 0;
  logic [7:0] d8 = 0;
  logic [7:0] c0, c1, c2, c3;
  logic       fv8, err8, busy8;
  logic [1:0] slot8;

  logic       v1 = 0, s1 = 0, d1 = 0;
  logic       e0, e1, e2, e3;
  logic       fv1, err1, busy1;
  logic [1:0] slot1;

  demux_4ch_tdm #(.W(8)) dut8 (
    .CK(CK), .RN(RN), .din_valid(v8), .sof(s8), .din(d8),
    .ch0(c0), .ch1(c1), .ch2(c2), .ch3(c3),
    .frame_valid(fv8), .frame_err(err8), .slot(slot8), .busy(busy8)
  );

  demux_4ch_tdm #(.W(1)) dut1 (
    .CK(CK), .RN(RN), .din_valid(v1), .sof(s1), .din(d1),
    .ch0(e0), .ch1(e1), .ch2(e2), .ch3(e3),
    .frame_valid(fv1), .frame_err(err1), .slot(slot1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: the current partial frame is just a queue of beats
  logic [7:0] mbuf[$];
  logic [7:0] mch[4];
  bit         mfv, merr;

  task automatic mreset();
    mbuf.delete();
    for (int i = 0; i < 4; i++) mch[i] = 8'h00;
    mfv = 0; merr = 0;
  endtask

  task automatic mstep(input bit v, input bit s, input logic [7:0] d);
    mfv = 0; merr = 0;
    if (v) begin
      if (s) begin
        if (mbuf.size() > 0) merr = 1;
        mbuf.delete();
        mbuf.push_back(d);
      end else if (mbuf.size() == 0) begin
        merr = 1;
      end else begin
        mbuf.push_back(d);
        if (mbuf.size() == 4) begin
          for (int i = 0; i < 4; i++) mch[i] = mbuf[i];
          mfv = 1;
          mbuf.delete();
        end
      end
    end
  endtask

  task automatic mcompare(input string tag);
    chk({tag, ".fv"},   fv8,   mfv);
    chk({tag, ".err"},  err8,  merr);
    chk({tag, ".slot"}, slot8, mbuf.size() % 4);
    chk({tag, ".busy"}, busy8, mbuf.size() != 0);
    chk({tag, ".ch"},   {c3, c2, c1, c0}, {mch[3], mch[2], mch[1], mch[0]});
  endtask

  task automatic step8(input bit v, input bit s, input logic [7:0] d, input string tag);
    v8 = v; s8 = s; d8 = d;
    @(posedge CK); #1;
    mstep(v, s, d);
    mcompare(tag);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".fv"},   fv8,   0);
    chk({tag, ".err"},  err8,  0);
    chk({tag, ".slot"}, slot8, 0);
    chk({tag, ".busy"}, busy8, 0);
    chk({tag, ".ch"},   {c3, c2, c1, c0}, 0);
  endtask

  typedef struct {
    bit         v, s;
    logic [7:0] d;
    bit         fv, err;
    logic [1:0] slot;
    logic [31:0] ch;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 1, 8'hA1, 0, 0, 2'd1, 32'h0};
    tbl[1]  = '{1, 0, 8'hB2, 0, 0, 2'd2, 32'h0};
    tbl[2]  = '{1, 0, 8'hC3, 0, 0, 2'd3, 32'h0};
    tbl[3]  = '{1, 0, 8'hD4, 1, 0, 2'd0, 32'hD4C3B2A1};
    tbl[4]  = '{1, 1, 8'h11, 0, 0, 2'd1, 32'hD4C3B2A1};
    tbl[5]  = '{1, 0, 8'h22, 0, 0, 2'd2, 32'hD4C3B2A1};
    tbl[6]  = '{1, 1, 8'h33, 0, 1, 2'd1, 32'hD4C3B2A1};
    tbl[7]  = '{1, 0, 8'h44, 0, 0, 2'd2, 32'hD4C3B2A1};
    tbl[8]  = '{1, 0, 8'h55, 0, 0, 2'd3, 32'hD4C3B2A1};
    tbl[9]  = '{1, 0, 8'h66, 1, 0, 2'd0, 32'h66554433};
    tbl[10] = '{1, 0, 8'h7F, 0, 1, 2'd0, 32'h66554433};
    tbl[11] = '{0, 1, 8'h99, 0, 0, 2'd0, 32'h66554433};
    tbl[12] = '{0, 0, 8'h00, 0, 0, 2'd0, 32'h66554433};

    mreset();
    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      v8 = 1'($urandom); s8 = 1'($urandom); d8 = 8'($urandom);
      v1 = 1'($urandom); s1 = 1'($urandom); d1 = 1'($urandom);
      @(posedge CK); #1;
    end
    zero_chk("rst_hold");
    v8 = 0; s8 = 0; d8 = 0; v1 = 0; s1 = 0; d1 = 0;
    #2 RN = 1'b1;
    @(posedge CK); #1;
    zero_chk("rst_rel");

    // directed table: single frame, early sof, stray beat, idle sof
    for (int i = 0; i < 13; i++) begin
      v8 = tbl[i].v; s8 = tbl[i].s; d8 = tbl[i].d;
      @(posedge CK); #1;
      mstep(tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d.fv", i),   fv8,   tbl[i].fv);
      chk($sformatf("tbl%0d.err", i),  err8,  tbl[i].err);
      chk($sformatf("tbl%0d.slot", i), slot8, tbl[i].slot);
      chk($sformatf("tbl%0d.busy", i), busy8, tbl[i].slot != 0);
      chk($sformatf("tbl%0d.ch", i),   {c3, c2, c1, c0}, tbl[i].ch);
    end

    // gapped frame followed immediately by a back-to-back frame
    step8(1, 1, 8'h01, "gap");
    for (int k = 1; k < 4; k++) begin
      repeat ($urandom_range(1, 3)) step8(0, 0, 8'($urandom), "gap_idle");
      step8(1, 0, 8'(k + 1), "gap");
    end
    chk("gap.ch1", {c3, c2, c1, c0}, 32'h04030201);
    for (int k = 0; k < 4; k++) begin
      step8(1, k == 0, 8'(8'hF0 + k), "b2b");
      if (k < 3) chk("b2b.hold", {c3, c2, c1, c0}, 32'h04030201);
    end
    chk("b2b.ch2", {c3, c2, c1, c0}, 32'hF3F2F1F0);

    // reset mid-frame after two beats
    step8(1, 1, 8'hAA, "mid");
    step8(1, 0, 8'hBB, "mid");
    #1 RN = 1'b0;
    #1;
    mreset();
    zero_chk("rst_mid");
    #2 RN = 1'b1;
    @(posedge CK); #1;
    step8(1, 1, 8'h5A, "post");
    step8(1, 0, 8'h6B, "post");
    step8(1, 0, 8'h7C, "post");
    step8(1, 0, 8'h8D, "post");
    chk("post.ch", {c3, c2, c1, c0}, 32'h8D7C6B5A);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step8($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 8'($urandom), "rnd");

    // W=1 exhaustive: 16 patterns back-to-back
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 4; k++) begin
        v1 = 1; s1 = (k == 0); d1 = p[k];
        @(posedge CK); #1;
        chk($sformatf("w1_%0d.fv", p), fv1, k == 3);
        chk($sformatf("w1_%0d.err", p), err1, 0);
      end
      chk($sformatf("w1_%0d.ch", p), {e3, e2, e1, e0}, p[3:0]);
    end
    v1 = 0;
    @(posedge CK); #1;
    chk("w1.idle", {busy1, slot1}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
